lfsr_shift_reg: RTL

//  Parametrised WIDTH-bit state register with synchronous parallel load, bidirectional serial shift and Fibonacci LFSR stepping.
//  It also keeps a step counter and flags period wrap and all-zero lockup.
//  It is the multi-bit successor of the single-bit loadable flip-flop.
//  It serves as the sequence/pattern generator in the datapath and testbench stimulus chains.

---
 rtl/lfsr_shift_reg.sv | 98 +++++++++
 1 files changed

// File: rtl/lfsr_shift_reg.sv
// lfsr_shift_reg: WIDTH-bit state register with parallel load, bidirectional serial shift,
// Fibonacci LFSR stepping, step counter, wrap pulse and lockup flag. Optional: LFSR_LOCKUP_RECOVER_EN.
module lfsr_shift_reg #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = 4'b0001,
    parameter int unsigned      CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadData,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic [CNT_W-1:0] StepCnt,
    output logic             Wrap,
    output logic             Lockup
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LFSR = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             fb;

    assign mode = mode_e'(Mode);
    assign fb   = ^(q_q & TAPS);

    always_comb begin
        q_d    = q_q;
        ref_d  = ref_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (Load) begin
            q_d   = LoadData;
            cnt_d = '0;
            // An all-zero load must not become the wrap reference.
            if (LoadData != '0) ref_d = LoadData;
        end else if (En) begin
            unique case (mode)
                MODE_HOLD: ;
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], SerIn};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                MODE_SHR: begin
                    q_d   = {SerIn, q_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                MODE_LFSR: begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                    if (q_q == '0) begin
                        q_d   = ref_q;
                        cnt_d = '0;
                    end else
`endif
                    begin
                        q_d    = {q_q[WIDTH-2:0], fb};
                        cnt_d  = cnt_q + CNT_W'(1);
                        wrap_d = ({q_q[WIDTH-2:0], fb} == ref_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_q    <= SEED;
            ref_q  <= SEED;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            ref_q  <= ref_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q       = q_q;
    assign StepCnt = cnt_q;
    assign Wrap    = wrap_q;
    assign SerOut  = (mode == MODE_SHR) ? q_q[0] : q_q[WIDTH-1];
    assign Lockup  = (mode == MODE_LFSR) && (q_q == '0);

endmodule
